// File: rtl/time_disp_pkg.sv
// Shared definitions for the time display scanner.
//   conv_state_e : state of the binary-to-BCD conversion sequencer
//   SEG_TABLE    : active-low 7-segment codes {g,f,e,d,c,b,a} for 0..9
//   NUM_DIGITS   : number of multiplexed digits on the display
//   seg_decode() : BCD digit to segment code; non-decimal codes stay dark
//   dabble_adj() : shift-add-3 correction for one BCD digit
package time_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] digit);
        logic [3:0] adj;
        if (digit >= 4'd5) begin
            adj = digit + 4'd3;
        end else begin
            adj = digit;
        end
        return adj;
    endfunction

endpackage

// File: rtl/time_display_scan_bin2bcd6.sv
// Sequential double-dabble converter, one input bit per clock.
//   clkin  : clock
//   reset  : asynchronous active-low reset
//   start  : load bin and begin a 6-cycle conversion
//   bin    : 6-bit binary value 0..63
//   tens   : BCD tens digit (0..6)
//   units  : BCD units digit (0..9)
//   done   : high during the final shift cycle; tens/units are final after that edge
module bin2bcd6
    import time_disp_pkg::*;
(
    input  logic       clkin,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       done
);

    logic [5:0] shift_r;
    logic [2:0] tens_r;
    logic [3:0] units_r;
    logic [2:0] cnt_r;
    logic       busy_r;
    logic [3:0] units_adj_s;
    logic       last_s;

    // Units correction before each shift; tens never exceeds 3 before a shift
    // for a 6-bit input, so it needs no correction and only three bits.
    always_comb begin
        units_adj_s = dabble_adj(units_r);
        last_s      = busy_r && (cnt_r == 3'd5);
    end

    // Shift register, BCD accumulators and bit counter
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            shift_r <= 6'd0;
            tens_r  <= 3'd0;
            units_r <= 4'd0;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b0;
        end else if (start) begin
            shift_r <= bin;
            tens_r  <= 3'd0;
            units_r <= 4'd0;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b1;
        end else if (busy_r) begin
            shift_r <= {shift_r[4:0], 1'b0};
            units_r <= {units_adj_s[2:0], shift_r[5]};
            tens_r  <= {tens_r[1:0], units_adj_s[3]};
            cnt_r   <= cnt_r + 3'd1;
            busy_r  <= !last_s;
        end else begin
            busy_r  <= 1'b0;
        end
    end

    assign tens  = {1'b0, tens_r};
    assign units = units_r;
    assign done  = last_s;

endmodule

// File: rtl/time_display_scan.sv
// Four-digit multiplexed clock display driver with blinking colon.
//   clkin   : sole clock
//   reset   : asynchronous active-low reset
//   hi_val  : left pair value 0..63 (asynchronous)
//   lo_val  : right pair value 0..63 (asynchronous)
//   blank   : darkens all digits and the colon while high
//   seg_n   : active-low segments {g,f,e,d,c,b,a}
//   an_n    : active-low digit enables, bit3 = leftmost
//   dp_n    : active-low decimal point used as the colon
// Inputs are synchronized and only a pair seen equal on two consecutive
// samples is converted; the four BCD digits land in the buffer together.
module time_display_scan
    import time_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_SLOTS = 500
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic [5:0] hi_val,
    input  logic [5:0] lo_val,
    input  logic       blank,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_SLOTS - 1);

    logic [5:0]  hi_meta_r, hi_sync_r, hi_prev_r;
    logic [5:0]  lo_meta_r, lo_sync_r, lo_prev_r;
    logic [5:0]  conv_hi_r, conv_lo_r;
    logic [5:0]  disp_hi_r, disp_lo_r;
    logic [15:0] disp_buf_r;
    conv_state_e state_r, state_nx_s;
    logic        pair_new_s, conv_start_s, load_s;
    logic [3:0]  hi_tens_s, hi_units_s, lo_tens_s, lo_units_s;
    logic        hi_done_s, lo_done_s;
    logic [PRESC_W-1:0] presc_r;
    logic        tick_s;
    logic [1:0]  dig_r;
    logic [BLINK_W-1:0] blink_r;
    logic        colon_r;
    logic [3:0]  an_sel_s, code_sel_s;
    logic [6:0]  seg_n_r;
    logic [3:0]  an_n_r;
    logic        dp_n_r;

    // Two-flop synchronizers plus the previous sample used for the stability test
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            hi_meta_r <= 6'd0;
            hi_sync_r <= 6'd0;
            hi_prev_r <= 6'd0;
            lo_meta_r <= 6'd0;
            lo_sync_r <= 6'd0;
            lo_prev_r <= 6'd0;
        end else begin
            hi_meta_r <= hi_val;
            hi_sync_r <= hi_meta_r;
            hi_prev_r <= hi_sync_r;
            lo_meta_r <= lo_val;
            lo_sync_r <= lo_meta_r;
            lo_prev_r <= lo_sync_r;
        end
    end

    // Conversion sequencer: next state and control strobes
    always_comb begin
        state_nx_s   = state_r;
        conv_start_s = 1'b0;
        load_s       = 1'b0;
        pair_new_s   = (hi_sync_r == hi_prev_r) && (lo_sync_r == lo_prev_r) &&
                       ((hi_sync_r != disp_hi_r) || (lo_sync_r != disp_lo_r));
        case (state_r)
            ST_IDLE: begin
                if (pair_new_s) begin
                    state_nx_s   = ST_CONV;
                    conv_start_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (hi_done_s && lo_done_s) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_CONV;
                end
            end
            ST_LOAD: begin
                load_s     = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Conversion sequencer state register
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture at start and atomic buffer update at load
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            conv_hi_r  <= 6'd0;
            conv_lo_r  <= 6'd0;
            disp_hi_r  <= 6'd0;
            disp_lo_r  <= 6'd0;
            disp_buf_r <= 16'h0000;
        end else if (conv_start_s) begin
            conv_hi_r <= hi_sync_r;
            conv_lo_r <= lo_sync_r;
        end else if (load_s) begin
            disp_hi_r  <= conv_hi_r;
            disp_lo_r  <= conv_lo_r;
            disp_buf_r <= {hi_tens_s, hi_units_s, lo_tens_s, lo_units_s};
        end else begin
            disp_buf_r <= disp_buf_r;
        end
    end

    bin2bcd6 u_conv_hi (
        .clkin (clkin),
        .reset (reset),
        .start (conv_start_s),
        .bin   (hi_sync_r),
        .tens  (hi_tens_s),
        .units (hi_units_s),
        .done  (hi_done_s)
    );

    bin2bcd6 u_conv_lo (
        .clkin (clkin),
        .reset (reset),
        .start (conv_start_s),
        .bin   (lo_sync_r),
        .tens  (lo_tens_s),
        .units (lo_units_s),
        .done  (lo_done_s)
    );

    assign tick_s = (presc_r == {PRESC_W{1'b0}});

    // Slot prescaler, digit index and colon blink counter
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            presc_r <= PRESC_RELOAD;
            dig_r   <= 2'd0;
            blink_r <= {BLINK_W{1'b0}};
            colon_r <= 1'b0;
        end else if (tick_s) begin
            presc_r <= PRESC_RELOAD;
            if (dig_r == 2'(NUM_DIGITS - 1)) begin
                dig_r <= 2'd0;
            end else begin
                dig_r <= dig_r + 2'd1;
            end
            if (blink_r == BLINK_LAST) begin
                blink_r <= {BLINK_W{1'b0}};
                colon_r <= !colon_r;
            end else begin
                blink_r <= blink_r + BLINK_W'(1);
            end
        end else begin
            presc_r <= presc_r - PRESC_W'(1);
        end
    end

    // Digit enable and BCD code for the selected digit
    always_comb begin
        an_sel_s   = 4'b1111;
        code_sel_s = 4'd0;
        case (dig_r)
            2'd0: begin
                an_sel_s   = 4'b1110;
                code_sel_s = disp_buf_r[3:0];
            end
            2'd1: begin
                an_sel_s   = 4'b1101;
                code_sel_s = disp_buf_r[7:4];
            end
            2'd2: begin
                an_sel_s   = 4'b1011;
                code_sel_s = disp_buf_r[11:8];
            end
            2'd3: begin
                an_sel_s   = 4'b0111;
                code_sel_s = disp_buf_r[15:12];
            end
            default: begin
                an_sel_s   = 4'b1111;
                code_sel_s = 4'd0;
            end
        endcase
    end

    // All three outputs registered together so they switch on the same edge
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            seg_n_r <= SEG_BLANK;
            an_n_r  <= 4'hF;
            dp_n_r  <= 1'b1;
        end else if (blank) begin
            seg_n_r <= SEG_BLANK;
            an_n_r  <= 4'hF;
            dp_n_r  <= 1'b1;
        end else begin
            seg_n_r <= seg_decode(code_sel_s);
            an_n_r  <= an_sel_s;
            dp_n_r  <= !((dig_r == 2'd2) && colon_r);
        end
    end

    assign seg_n = seg_n_r;
    assign an_n  = an_n_r;
    assign dp_n  = dp_n_r;

endmodule
